// File: rtl/stack_alu.sv
// stack_alu: 16-bit registered ALU (CPY/ADD/NEGY/OR/NOTY/CPX/INX/DCX) with SF/CF/ZF/OF flags; ALU_FLAG_HOLD_EN keeps CF/OF on logical ops.
// Latency: 1 cycle from in_valid sample to z/Flags with out_valid; one request per cycle.
// Backpressure: none; the consumer must take the result in the out_valid cycle.
module stack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       ALOP,
  input  logic             in_valid,
  output logic [WIDTH-1:0] z,
  output logic [3:0]       Flags,
  output logic             out_valid
);

  localparam logic [2:0] OP_CPY  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_NEGY = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOTY = 3'd4;
  localparam logic [2:0] OP_CPX  = 3'd5;
  localparam logic [2:0] OP_INX  = 3'd6;
  localparam logic [2:0] OP_DCX  = 3'd7;

  localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] z_q, z_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] res;
  logic             cf;
  logic             of;
  logic             cf_keep;
  logic             of_keep;

  // Value CF/OF take on CPY/OR/NOTY/CPX.
`ifdef ALU_FLAG_HOLD_EN
  assign cf_keep = flags_q[1];
  assign of_keep = flags_q[3];
`else
  assign cf_keep = 1'b0;
  assign of_keep = 1'b0;
`endif

  always_comb begin
    add_sum = {1'b0, x} + {1'b0, y};
    inc_sum = {1'b0, x} + {1'b0, ONE};
    res     = y;
    cf      = cf_keep;
    of      = of_keep;
    case (ALOP)
      OP_CPY: res = y;
      OP_ADD: begin
        res = add_sum[WIDTH-1:0];
        cf  = add_sum[WIDTH];
        of  = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_NEGY: begin
        res = -y;
        cf  = |y;
        of  = (y == SIGN_MIN);
      end
      OP_OR:   res = x | y;
      OP_NOTY: res = ~y;
      OP_CPX:  res = x;
      OP_INX: begin
        res = inc_sum[WIDTH-1:0];
        cf  = inc_sum[WIDTH];
        of  = (x == POS_MAX);
      end
      OP_DCX: begin
        res = x - ONE;
        cf  = ~|x;
        of  = (x == SIGN_MIN);
      end
    endcase
  end

  always_comb begin
    z_d         = z_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      z_d     = res;
      flags_d = {of, ~|res, cf, res[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign Flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed vectors plus randomized requests against an integer-arithmetic reference model.
// Define ALU_FLAG_HOLD_EN for both DUT and bench to check the flag-hold build.
module tb_stack_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic [2:0]  ALOP;
  logic        in_valid;
  logic [15:0] z;
  logic [3:0]  Flags;
  logic        out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: last result and flags, as the consumer would see them.
  logic [15:0] m_z;
  logic [3:0]  m_flags;

  stack_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .ALOP      (ALOP),
    .in_valid  (in_valid),
    .z         (z),
    .Flags     (Flags),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Flags computed from signed/unsigned integer ranges rather than bit tricks.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, ur, sr;
    logic cf, of, arith;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    arith = 1'b1;
    ur = 0;
    sr = 0;
    case (op)
      3'd0: begin ur = ub; arith = 1'b0; end
      3'd1: begin ur = ua + ub; sr = sa + sb; end
      3'd2: begin ur = -ub;     sr = -sb;     end
      3'd3: begin ur = ua | ub; arith = 1'b0; end
      3'd4: begin ur = 65535 - ub; arith = 1'b0; end
      3'd5: begin ur = ua; arith = 1'b0; end
      3'd6: begin ur = ua + 1;  sr = sa + 1;  end
      default: begin ur = ua - 1; sr = sa - 1; end
    endcase
    if (arith) begin
      cf = (ur < 0) || (ur > 65535);
      of = (sr < -32768) || (sr > 32767);
    end else begin
`ifdef ALU_FLAG_HOLD_EN
      cf = m_flags[1];
      of = m_flags[3];
`else
      cf = 1'b0;
      of = 1'b0;
`endif
    end
    m_z = 16'(ur & 32'hFFFF);
    m_flags = {of, (m_z == 16'd0), cf, (m_z >= 16'h8000)};
  endtask

  // Drive at negedge, compare #1 after the following posedge.
  task automatic issue(input logic vld, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input string tag);
    @(negedge clk);
    in_valid = vld;
    ALOP = op;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    if (vld) model(op, a, b);
    check({tag, ".z"}, 32'(z), 32'(m_z));
    check({tag, ".flags"}, 32'(Flags), 32'(m_flags));
    check({tag, ".vld"}, 32'(out_valid), 32'(vld));
  endtask

  task automatic directed(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ez, input logic [3:0] ef, input string tag);
    issue(1'b1, op, a, b, tag);
    check({tag, ".z_const"}, 32'(z), 32'(ez));
    check({tag, ".f_const"}, 32'(Flags), 32'(ef));
  endtask

  logic [15:0] tz [8];
  logic [3:0]  tf [8];
  logic [2:0]  top [8];

  initial begin
    int vcount;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    ALOP = 3'd0;
    x = 16'd0;
    y = 16'd0;
    m_z = 16'd0;
    m_flags = 4'd0;
    #12;
    check("reset.z", 32'(z), 32'd0);
    check("reset.flags", 32'(Flags), 32'd0);
    check("reset.vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    top = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    tz  = '{16'h3E47, 16'hC669, 16'h3DB7, 16'hC668, 16'h04B0, 16'h04B1, 16'h04AF, 16'h3997};
    tf  = '{4'b0000, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      directed(top[i], 16'h04B0, 16'h3997, tz[i], tf[i], $sformatf("seq%0d", i));
      issue(1'b0, 3'd0, 16'd0, 16'd0, "seq_gap");
    end

    directed(3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, "add_carry");
    directed(3'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, "add_ovf");
    directed(3'd6, 16'h7FFF, 16'h0000, 16'h8000, 4'b1001, "inx_ovf");
    directed(3'd7, 16'h0000, 16'h0000, 16'hFFFF, 4'b0011, "dcx_borrow");
    directed(3'd7, 16'h8000, 16'h0000, 16'h7FFF, 4'b1000, "dcx_ovf");
    directed(3'd2, 16'h0000, 16'h8000, 16'h8000, 4'b1011, "negy_min");
    directed(3'd2, 16'h0000, 16'h0000, 16'h0000, 4'b0100, "negy_zero");

    directed(3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, "hold_add");
`ifdef ALU_FLAG_HOLD_EN
    directed(3'd3, 16'h0000, 16'h0000, 16'h0000, 4'b0110, "hold_or");
`else
    directed(3'd3, 16'h0000, 16'h0000, 16'h0000, 4'b0100, "hold_or");
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk);
    in_valid = 1'b1;
    ALOP = 3'd1;
    x = 16'h1234;
    y = 16'h1111;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.z", 32'(z), 32'd0);
    check("arst.flags", 32'(Flags), 32'd0);
    check("arst.vld", 32'(out_valid), 32'd0);
    m_z = 16'd0;
    m_flags = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b0, 3'd1, 16'h5555, 16'h1111, $sformatf("idle%0d", i));

    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 3'(i + 1), 16'h0100 + 16'(i), 16'h0010, $sformatf("b2b%0d", i));
      if (out_valid) vcount++;
    end
    issue(1'b0, 3'd0, 16'd0, 16'd0, "b2b_end");
    check("b2b.count", 32'(vcount), 32'd4);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: ra = 16'($urandom_range(0, 2) == 0 ? 0 : 16'hFFFF);
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'd0;
      issue($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), ra, rb, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_alu.md
# stack_alu

16-bit registered arithmetic/logic unit for the stack CPU datapath. It takes two operands, x and y, and a 3-bit operation code. On the clock edge after a valid request it produces a 16-bit result and a 4-bit status flag vector. The result and flags feed the stack write-back path and the branch/condition logic.

## Interface
Parameters:
- WIDTH, 16, operand/result width; flag rules below assume bit WIDTH-1 is the sign bit.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- x  input  WIDTH  first operand
- y  input  WIDTH  second operand
- ALOP  input  3  operation code
- in_valid  input  1  request strobe; operands/ALOP sampled when high
- z  output  WIDTH  registered result
- Flags  output  4  registered flags: bit0 SF, bit1 CF, bit2 ZF, bit3 OF
- out_valid  output  1  high for one cycle when z/Flags hold a new result

## Operation
Opcodes:
- 0 CPY: z = y
- 1 ADD: z = x + y
- 2 NEGY: z = 0 − y
- 3 OR: z = x | y
- 4 NOTY: z = ~y
- 5 CPX: z = x
- 6 INX: z = x + 1
- 7 DCX: z = x − 1

Flag rules (computed on the new z):
- SF = z[WIDTH-1] for all ops.
- ZF = (z == 0) for all ops.
- CF:
  - ADD and INX: carry-out of the unsigned sum.
  - NEGY: borrow, i.e. 1 iff y ≠ 0.
  - DCX: borrow, i.e. 1 iff x == 0.
  - CPY/OR/NOTY/CPX: 0 (see Configuration).
- OF:
  - ADD: 1 iff x and y have the same sign and z's sign differs.
  - NEGY: 1 iff y == 0x8000.
  - INX: 1 iff x == 0x7FFF.
  - DCX: 1 iff x == 0x8000.
  - Other ops: 0 (see Configuration).
- All arithmetic wraps modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst_n low, asynchronous): z = 0, Flags = 0, out_valid = 0. These hold until the first clk edge with rst_n high and in_valid high.
- Latency 1 cycle: the request sampled at edge N appears on z/Flags, with out_valid = 1, after edge N.
- Throughput 1 per cycle; back-to-back requests are allowed, and out_valid stays high while in_valid stays high.
- in_valid low at an edge: z and Flags hold their previous values; out_valid = 0.
- No backpressure; the consumer must take the result in the out_valid cycle.
- Reset asserted mid-stream discards the in-flight result; out_valid is 0 on the first cycle after deassertion.
- ALOP, x and y must be stable around the sampling edge only; there are no combinational paths from inputs to outputs.

## Configuration
- ALU_FLAG_HOLD_EN defined: CPY, OR, NOTY and CPX leave CF and OF at their previous registered values. SF and ZF still update.
- ALU_FLAG_HOLD_EN undefined (default): those ops clear CF and OF to 0, as in Operation.

## Test plan
Each scenario asserts in_valid for one cycle and checks z, Flags and out_valid one cycle later.
- x=0x04B0, y=0x3997, ALOP sequence 1,2,3,4,5,6,7,0 → z = 0x3E47, 0xC669, 0x3DB7, 0xC668, 0x04B0, 0x04B1, 0x04AF, 0x3997. Flags (OF ZF CF SF) = 0000, 0011, 0000, 0001, 0000, 0000, 0000, 0000.
- ADD x=0xFFFF, y=0x0001 → z=0x0000, Flags=0110. ADD x=0x7FFF, y=0x0001 → z=0x8000, Flags=1001.
- INX x=0x7FFF → z=0x8000, Flags=1001. DCX x=0x0000 → z=0xFFFF, Flags=0011. DCX x=0x8000 → z=0x7FFF, Flags=1000.
- NEGY y=0x8000 → z=0x8000, Flags=1011. NEGY y=0 → z=0, Flags=0100.
- Reset and handshake:
  - Assert rst_n=0 asynchronously mid-stream → z, Flags and out_valid go to 0 immediately.
  - After release, in_valid low for 3 cycles → outputs hold 0 and out_valid stays 0.
  - Then 4 back-to-back requests → out_valid high for exactly 4 consecutive cycles.
- With ALU_FLAG_HOLD_EN: ADD 0xFFFF+0x0001 (CF=1), then OR x=0, y=0 → Flags=0110, with CF retained. Without the macro, the same sequence gives Flags=0100.
